// File: rtl/bc_guess_scorer_if.sv
`default_nettype none
// ============================================================================
// Module      : bc_guess_scorer_if
// Description : Bundle of the game-core signals between the input stage and
//               the scorer. The master side supplies the synchronised digit
//               entry and the save strobe; the slave side (the scorer)
//               returns the score, status flags and 7-segment pattern.
// Signals     : inp_a..inp_d  3-bit digits for positions 0..3
//               save          single-cycle entry strobe
//               segment_out   {dp,g,f,e,d,c,b,a}, active high
//               bulls, cows   score of the last guess (0..4)
//               result_valid  bulls/cows belong to the current game
//               busy          scoring in progress
//               tries         scored guesses in the current game
//               win, lose     end-of-game flags
//               entry_err     last save rejected (repeated digit)
// Revision    : 1.0 - initial release
// ============================================================================
interface bc_guess_scorer_if;
    logic [2:0] inp_a;
    logic [2:0] inp_b;
    logic [2:0] inp_c;
    logic [2:0] inp_d;
    logic       save;
    logic [7:0] segment_out;
    logic [2:0] bulls;
    logic [2:0] cows;
    logic       result_valid;
    logic       busy;
    logic [3:0] tries;
    logic       win;
    logic       lose;
    logic       entry_err;

    modport master (
        output inp_a, inp_b, inp_c, inp_d, save,
        input  segment_out, bulls, cows, result_valid, busy, tries,
        input  win, lose, entry_err
    );

    modport slave (
        input  inp_a, inp_b, inp_c, inp_d, save,
        output segment_out, bulls, cows, result_valid, busy, tries,
        output win, lose, entry_err
    );
endinterface
`default_nettype wire

// File: rtl/bc_guess_scorer.sv
`default_nettype none
// ============================================================================
// Module      : bc_guess_scorer
// Description : Bulls-and-cows game core. Latches the first distinct-digit
//               entry as the secret, scores each later guess over a
//               4-cycle sequential compare plus one commit cycle, tracks
//               tries and win/lose, and drives a single 7-segment digit.
// Ports       : clk    system clock
//               rst_n  asynchronous active-low reset
//               bus    bc_guess_scorer_if.slave (entry in, score/status out)
// Parameters  : MAX_TRIES    scored guesses before loss (1..15)
//               SHOW_CYCLES  cycles per bulls/cows display phase (>= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module bc_guess_scorer #(
    parameter int unsigned MAX_TRIES   = 15,
    parameter logic [23:0] SHOW_CYCLES = 24'd6_000_000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bc_guess_scorer_if.slave   bus
);

    localparam logic [2:0] S_SECRET = 3'd0;
    localparam logic [2:0] S_GUESS  = 3'd1;
    localparam logic [2:0] S_SCORE  = 3'd2;
    localparam logic [2:0] S_WIN    = 3'd3;
    localparam logic [2:0] S_LOSE   = 3'd4;

    localparam logic [3:0]  c_max_tries = 4'(MAX_TRIES);
    localparam logic [23:0] c_show_last = SHOW_CYCLES - 24'd1;
    localparam logic [2:0]  c_commit_idx = 3'd4;

    localparam logic [7:0] c_seg_err  = 8'h79;
    localparam logic [7:0] c_seg_dash = 8'h40;
    localparam logic [7:0] c_seg_undr = 8'h08;
    localparam logic [7:0] c_seg_win  = 8'h73;
    localparam logic [7:0] c_seg_lose = 8'h38;

    // Registered state
    logic [2:0]  r_state;
    logic [2:0]  r_secret [0:3];
    logic [2:0]  r_guess  [0:3];
    logic [2:0]  r_idx;
    logic [2:0]  r_bacc;
    logic [2:0]  r_cacc;
    logic [2:0]  r_bulls;
    logic [2:0]  r_cows;
    logic [3:0]  r_tries;
    logic        r_result_valid;
    logic        r_entry_err;
    logic        r_busy;
    logic        r_win;
    logic        r_lose;
    logic [7:0]  r_seg;
    logic        r_phase;
    logic [23:0] r_phase_cnt;

    // Combinational next values
    logic [2:0]  w_entry [0:3];
    logic        w_distinct;
    logic [1:0]  w_pos;
    logic        w_is_bull;
    logic        w_is_cow;
    logic [3:0]  w_tries_inc;
    logic [2:0]  w_state_nxt;
    logic        w_err_nxt;
    logic        w_rv_nxt;
    logic [2:0]  w_bulls_nxt;
    logic [2:0]  w_cows_nxt;
    logic [3:0]  w_tries_nxt;
    logic        w_latch_secret;
    logic        w_latch_guess;
    logic        w_commit;
    logic        w_phase_nxt;
    logic [23:0] w_cnt_nxt;
    logic [7:0]  w_seg_nxt;

    function automatic logic [6:0] f_digit(input logic [2:0] v);
        logic [6:0] seg;
        case (v)
            3'd0:    seg = 7'h3F;
            3'd1:    seg = 7'h06;
            3'd2:    seg = 7'h5B;
            3'd3:    seg = 7'h4F;
            3'd4:    seg = 7'h66;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign w_entry[0] = bus.inp_a;
    assign w_entry[1] = bus.inp_b;
    assign w_entry[2] = bus.inp_c;
    assign w_entry[3] = bus.inp_d;

    assign w_distinct = (w_entry[0] != w_entry[1]) && (w_entry[0] != w_entry[2]) &&
                        (w_entry[0] != w_entry[3]) && (w_entry[1] != w_entry[2]) &&
                        (w_entry[1] != w_entry[3]) && (w_entry[2] != w_entry[3]);

    // One guess position per cycle; a cow is a digit present elsewhere in the
    // secret, so the bull test takes precedence over the any-position match.
    assign w_pos     = r_idx[1:0];
    assign w_is_bull = (r_guess[w_pos] == r_secret[w_pos]);
    assign w_is_cow  = !w_is_bull &&
                       ((r_guess[w_pos] == r_secret[0]) || (r_guess[w_pos] == r_secret[1]) ||
                        (r_guess[w_pos] == r_secret[2]) || (r_guess[w_pos] == r_secret[3]));

    assign w_tries_inc = r_tries + 4'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_err_nxt      = r_entry_err;
        w_rv_nxt       = r_result_valid;
        w_bulls_nxt    = r_bulls;
        w_cows_nxt     = r_cows;
        w_tries_nxt    = r_tries;
        w_latch_secret = 1'b0;
        w_latch_guess  = 1'b0;
        w_commit       = 1'b0;

        case (r_state)
            S_SECRET: begin
                if (bus.save) begin
                    if (w_distinct) begin
                        w_latch_secret = 1'b1;
                        w_err_nxt      = 1'b0;
                        w_state_nxt    = S_GUESS;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_GUESS: begin
                if (bus.save) begin
                    if (w_distinct) begin
                        w_latch_guess = 1'b1;
                        w_err_nxt     = 1'b0;
                        w_state_nxt   = S_SCORE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_SCORE: begin
                if (r_idx == c_commit_idx) begin
                    w_commit    = 1'b1;
                    w_bulls_nxt = r_bacc;
                    w_cows_nxt  = r_cacc;
                    w_rv_nxt    = 1'b1;
                    w_tries_nxt = w_tries_inc;
                    if (r_bacc == 3'd4) begin
                        w_state_nxt = S_WIN;
                    end else if (w_tries_inc == c_max_tries) begin
                        w_state_nxt = S_LOSE;
                    end else begin
                        w_state_nxt = S_GUESS;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                // The new-game save only resets the game; it is not a secret.
                if (bus.save) begin
                    w_tries_nxt = 4'd0;
                    w_rv_nxt    = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_SECRET;
                end
            end
            default: begin
                w_state_nxt = S_SECRET;
            end
        endcase
    end

    // Bulls/cows alternation timer; restarts on the bulls phase at each commit.
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_phase_cnt;
        if (w_commit) begin
            w_phase_nxt = 1'b0;
            w_cnt_nxt   = 24'd0;
        end else if (((r_state == S_GUESS) || (r_state == S_SCORE)) && r_result_valid) begin
            if (r_phase_cnt == c_show_last) begin
                w_cnt_nxt   = 24'd0;
                w_phase_nxt = !r_phase;
            end else begin
                w_cnt_nxt = r_phase_cnt + 24'd1;
            end
        end else begin
            w_phase_nxt = 1'b0;
            w_cnt_nxt   = 24'd0;
        end
    end

    // Display pattern derived from the next-state values so that the
    // registered segment output lines up with the other registered outputs.
    always_comb begin
        w_seg_nxt = c_seg_dash;
        if (w_err_nxt) begin
            w_seg_nxt = c_seg_err;
        end else begin
            case (w_state_nxt)
                S_SECRET: w_seg_nxt = c_seg_dash;
                S_GUESS, S_SCORE: begin
                    if (!w_rv_nxt) begin
                        w_seg_nxt = c_seg_undr;
                    end else if (w_phase_nxt) begin
                        w_seg_nxt = {1'b1, f_digit(w_cows_nxt)};
                    end else begin
                        w_seg_nxt = {1'b0, f_digit(w_bulls_nxt)};
                    end
                end
                S_WIN:   w_seg_nxt = c_seg_win;
                S_LOSE:  w_seg_nxt = c_seg_lose;
                default: w_seg_nxt = c_seg_dash;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_SECRET;
            r_secret       <= '{3'd0, 3'd0, 3'd0, 3'd0};
            r_guess        <= '{3'd0, 3'd0, 3'd0, 3'd0};
            r_idx          <= 3'd0;
            r_bacc         <= 3'd0;
            r_cacc         <= 3'd0;
            r_bulls        <= 3'd0;
            r_cows         <= 3'd0;
            r_tries        <= 4'd0;
            r_result_valid <= 1'b0;
            r_entry_err    <= 1'b0;
            r_busy         <= 1'b0;
            r_win          <= 1'b0;
            r_lose         <= 1'b0;
            r_seg          <= c_seg_dash;
            r_phase        <= 1'b0;
            r_phase_cnt    <= 24'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_bulls        <= w_bulls_nxt;
            r_cows         <= w_cows_nxt;
            r_tries        <= w_tries_nxt;
            r_result_valid <= w_rv_nxt;
            r_entry_err    <= w_err_nxt;
            r_busy         <= (w_state_nxt == S_SCORE);
            r_win          <= (w_state_nxt == S_WIN);
            r_lose         <= (w_state_nxt == S_LOSE);
            r_seg          <= w_seg_nxt;
            r_phase        <= w_phase_nxt;
            r_phase_cnt    <= w_cnt_nxt;

            if (w_latch_secret) begin
                r_secret <= w_entry;
            end

            if (w_latch_guess) begin
                r_guess <= w_entry;
                r_idx   <= 3'd0;
                r_bacc  <= 3'd0;
                r_cacc  <= 3'd0;
            end else if ((r_state == S_SCORE) && (r_idx != c_commit_idx)) begin
                r_idx <= r_idx + 3'd1;
                if (w_is_bull) begin
                    r_bacc <= r_bacc + 3'd1;
                end else if (w_is_cow) begin
                    r_cacc <= r_cacc + 3'd1;
                end
            end
        end
    end

    assign bus.segment_out  = r_seg;
    assign bus.bulls        = r_bulls;
    assign bus.cows         = r_cows;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = r_busy;
    assign bus.tries        = r_tries;
    assign bus.win          = r_win;
    assign bus.lose         = r_lose;
    assign bus.entry_err    = r_entry_err;

endmodule
`default_nettype wire

// File: tb/tb_bc_guess_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bc_guess_scorer
// Description : Self-checking bench for bc_guess_scorer. A game-level model
//               (secret array, scores computed at save time, commit five
//               cycles later, display phase from cycles-since-commit) is
//               compared with every DUT output each cycle, alongside
//               directed scenarios with literal expectations and a
//               randomized play phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bc_guess_scorer;

    localparam int MAXT = 3;
    localparam int SHOW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    bc_guess_scorer_if bif ();

    bc_guess_scorer #(
        .MAX_TRIES   (MAXT),
        .SHOW_CYCLES (24'(SHOW))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_st: 0 secret, 1 guess, 2 scoring, 3 win, 4 lose
    int m_st, m_cnt, m_pb, m_pc, m_bulls, m_cows, m_tries, m_since;
    bit m_rv, m_err;
    int m_sec [4];
    int g [4];

    function automatic bit all_distinct(int a, int b, int c, int d);
        return (a != b) && (a != c) && (a != d) && (b != c) && (b != d) && (c != d);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_pb = 0; m_pc = 0;
            m_bulls = 0; m_cows = 0; m_tries = 0; m_since = 0;
            m_rv = 0; m_err = 0;
            m_sec = '{0, 0, 0, 0};
        end else begin
            g[0] = int'(bif.inp_a); g[1] = int'(bif.inp_b);
            g[2] = int'(bif.inp_c); g[3] = int'(bif.inp_d);
            m_since++;
            case (m_st)
                0: if (bif.save) begin
                    if (all_distinct(g[0], g[1], g[2], g[3])) begin
                        m_sec = g; m_err = 0; m_st = 1;
                    end else m_err = 1;
                end
                1: if (bif.save) begin
                    if (all_distinct(g[0], g[1], g[2], g[3])) begin
                        m_pb = 0; m_pc = 0;
                        foreach (g[i]) begin
                            if (g[i] == m_sec[i]) m_pb++;
                            else if (g[i] inside {m_sec[0], m_sec[1], m_sec[2], m_sec[3]}) m_pc++;
                        end
                        m_err = 0; m_cnt = 0; m_st = 2;
                    end else m_err = 1;
                end
                2: begin
                    m_cnt++;
                    if (m_cnt == 5) begin
                        m_bulls = m_pb; m_cows = m_pc; m_rv = 1;
                        m_tries++; m_since = 0;
                        if (m_pb == 4) m_st = 3;
                        else if (m_tries == MAXT) m_st = 4;
                        else m_st = 1;
                    end
                end
                default: if (bif.save) begin
                    m_tries = 0; m_rv = 0; m_err = 0; m_st = 0;
                end
            endcase
        end
    end

    function automatic int seg_of(int v);
        case (v)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_seg();
        bit ph;
        if (m_err) return 'h79;
        case (m_st)
            0: return 'h40;
            1, 2: begin
                if (!m_rv) return 'h08;
                ph = ((m_since / SHOW) % 2) == 1;
                return ph ? (seg_of(m_cows) | 'h80) : seg_of(m_bulls);
            end
            3: return 'h73;
            default: return 'h38;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("segment_out",  int'(bif.segment_out),  exp_seg());
            chk("bulls",        int'(bif.bulls),        m_bulls);
            chk("cows",         int'(bif.cows),         m_cows);
            chk("tries",        int'(bif.tries),        m_tries);
            chk("result_valid", int'(bif.result_valid), int'(m_rv));
            chk("entry_err",    int'(bif.entry_err),    int'(m_err));
            chk("busy",         int'(bif.busy),         int'(m_st == 2));
            chk("win",          int'(bif.win),          int'(m_st == 3));
            chk("lose",         int'(bif.lose),         int'(m_st == 4));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(int a, int b, int c, int d);
        bif.inp_a = 3'(a); bif.inp_b = 3'(b); bif.inp_c = 3'(c); bif.inp_d = 3'(d);
    endtask

    task automatic do_save(int a, int b, int c, int d);
        @(posedge clk); #2;
        set_in(a, b, c, d);
        bif.save = 1'b1;
        @(posedge clk); #2;
        bif.save = 1'b0;
    endtask

    task automatic guess_wait(int a, int b, int c, int d);
        do_save(a, b, c, d);
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d [4];
        int r;
        bit dbl;
        set_in(0, 0, 0, 0);
        bif.save = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset segment", int'(bif.segment_out), 'h40);
        chk("reset tries",   int'(bif.tries), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Secret 0123 then guess 3210: all cows, display alternates
        do_save(0, 1, 2, 3);
        @(negedge clk);
        chk("secret accepted segment", int'(bif.segment_out), 'h08);
        guess_wait(3, 2, 1, 0);
        chk("g1 bulls", int'(bif.bulls), 0);
        chk("g1 cows",  int'(bif.cows), 4);
        chk("g1 tries", int'(bif.tries), 1);
        chk("g1 seg bulls phase", int'(bif.segment_out), 'h3F);
        repeat (SHOW) @(negedge clk);
        chk("g1 seg cows phase", int'(bif.segment_out), 'hE6);
        guess_wait(0, 1, 2, 3);
        chk("g1 win", int'(bif.win), 1);
        do_save(0, 0, 0, 0);

        // Secret 5670: one bull one cow, then a win on try 2
        do_save(5, 6, 7, 0);
        guess_wait(5, 7, 1, 2);
        chk("g2 bulls", int'(bif.bulls), 1);
        chk("g2 cows",  int'(bif.cows), 1);
        guess_wait(5, 6, 7, 0);
        chk("g2 bulls win", int'(bif.bulls), 4);
        chk("g2 win", int'(bif.win), 1);
        chk("g2 seg", int'(bif.segment_out), 'h73);
        chk("g2 tries", int'(bif.tries), 2);
        do_save(1, 1, 1, 1);

        // Repeated digit in the secret is rejected
        do_save(1, 1, 2, 3);
        @(negedge clk);
        chk("err flag", int'(bif.entry_err), 1);
        chk("err seg", int'(bif.segment_out), 'h79);
        do_save(1, 4, 2, 3);
        @(negedge clk);
        chk("err cleared", int'(bif.entry_err), 0);
        chk("err cleared seg", int'(bif.segment_out), 'h08);

        // save held through the whole scoring window is ignored
        @(posedge clk); #2;
        set_in(0, 1, 2, 3);
        bif.save = 1'b1;
        repeat (6) @(posedge clk);
        #2 bif.save = 1'b0;
        @(negedge clk);
        chk("held save tries", int'(bif.tries), 1);
        chk("held save bulls", int'(bif.bulls), 2);
        chk("held save cows",  int'(bif.cows), 1);
        do_save(2, 2, 3, 4);
        @(negedge clk);
        chk("invalid guess tries", int'(bif.tries), 1);
        chk("invalid guess err", int'(bif.entry_err), 1);

        // Lose on reaching MAX_TRIES
        guess_wait(5, 6, 7, 0);
        guess_wait(5, 6, 7, 0);
        chk("lose flag", int'(bif.lose), 1);
        chk("lose seg", int'(bif.segment_out), 'h38);
        chk("lose tries", int'(bif.tries), MAXT);
        do_save(0, 0, 0, 0);
        @(negedge clk);
        chk("new game tries", int'(bif.tries), 0);

        // Win on the final allowed try beats lose
        do_save(0, 1, 2, 3);
        guess_wait(4, 5, 6, 7);
        guess_wait(4, 5, 6, 7);
        guess_wait(0, 1, 2, 3);
        chk("last try win", int'(bif.win), 1);
        chk("last try no lose", int'(bif.lose), 0);

        // Reset in the middle of scoring
        do_save(0, 0, 0, 0);
        do_save(0, 1, 2, 3);
        do_save(1, 0, 3, 2);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid reset busy",  int'(bif.busy), 0);
        chk("mid reset bulls", int'(bif.bulls), 0);
        chk("mid reset seg",   int'(bif.segment_out), 'h40);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("post reset valid", int'(bif.result_valid), 0);
        chk("post reset tries", int'(bif.tries), 0);

        // Randomized play
        for (int it = 0; it < 500; it++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            r = int'($urandom_range(0, 9));
            if (r < 3 && m_st == 1) begin
                d = m_sec;
            end else if (r < 8) begin
                d[0] = int'($urandom_range(0, 7));
                for (int k = 1; k < 4; k++) begin
                    d[k] = int'($urandom_range(0, 7));
                    for (int t = 0; t < 64; t++) begin
                        if ((k > 0 && d[k] == d[0]) || (k > 1 && d[k] == d[1]) ||
                            (k > 2 && d[k] == d[2]))
                            d[k] = int'($urandom_range(0, 7));
                    end
                end
            end else begin
                foreach (d[k]) d[k] = int'($urandom_range(0, 7));
            end
            dbl = ($urandom_range(0, 99) < 15);
            @(posedge clk); #2;
            set_in(d[0], d[1], d[2], d[3]);
            bif.save = 1'b1;
            @(posedge clk);
            if (dbl) @(posedge clk);
            #2 bif.save = 1'b0;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
